// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage sub-word access sequencer.
package mem_ctrl_pkg;

  localparam int unsigned HALF_W = 16;

  // Sequencer states; encodings are fixed so traces read the same across tools.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LD_RD = 2'd1,
    SH_RD = 2'd2,
    SH_WR = 2'd3
  } state_t;

  // Halfword lane select taken from byte-address bit 1 (big-endian lanes).
  localparam logic LANE_HI = 1'b0;  // bits [31:16]
  localparam logic LANE_LO = 1'b1;  // bits [15:0]

endpackage

// File: rtl/hw_lane_sel.sv
// Halfword lane merge/extract: replaces the addressed halfword of a word and
// returns the addressed halfword sign-extended to the full word width.
module hw_lane_sel
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned data_size = 32
) (
  input  logic [data_size-1:0] word,
  input  logic                 lane,
  input  logic [HALF_W-1:0]    new_half,
  output logic [data_size-1:0] merged_c,
  output logic [data_size-1:0] ext_half_c
);

  localparam int unsigned EXT_W = data_size - HALF_W;

  logic [HALF_W-1:0] half_c;

  // Lane steering for both the store merge and the load extract.
  always_comb begin
    merged_c = word;
    half_c   = word[HALF_W-1:0];
    if (lane == LANE_HI) begin
      merged_c[data_size-1 -: HALF_W] = new_half;
      half_c                          = word[data_size-1 -: HALF_W];
    end else begin
      merged_c[HALF_W-1:0] = new_half;
    end
    ext_half_c = {{EXT_W{half_c[HALF_W-1]}}, half_c};
  end

endmodule

// File: rtl/mem_subword_ctrl.sv
// MEM-stage sequencer: one-cycle sw, two-cycle lw/lh, three-cycle sh via
// read-modify-write against a synchronous-read, word-addressed data memory.
// Outputs are combinational on purpose: the memory and the pipeline need
// dm_wen/dm_addr/mem_stall in the same cycle the instruction sits in MEM.
module mem_subword_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned data_size = 32,
  parameter int unsigned addr_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemtoReg,
  input  logic                 M_MemWrite,
  input  logic                 M_lh,
  input  logic                 M_sh,
  input  logic [data_size-1:0] M_ALU_result,
  input  logic [data_size-1:0] M_Rt_data,
  input  logic [data_size-1:0] dm_rdata,
  output logic [addr_size-1:0] dm_addr,
  output logic                 dm_wen,
  output logic [data_size-1:0] dm_wdata,
  output logic                 mem_stall,
  output logic [data_size-1:0] M_ld_data,
  output logic                 M_ld_valid
);

  state_t               state_q;
  state_t               state_d;
  logic [data_size-1:0] merge_q;
  logic [data_size-1:0] ld_hold_q;
  logic [data_size-1:0] merged_c;
  logic [data_size-1:0] ext_half_c;
  logic [data_size-1:0] ld_val_c;
  logic                 unused_addr_bits;

  // Word address straight from the byte address; EX/M is held during a sequence.
  assign dm_addr          = M_ALU_result[addr_size+1:2];
  assign unused_addr_bits = ^{M_ALU_result[0], M_ALU_result[data_size-1:addr_size+2]};

  // One lane unit serves both the lh extract and the sh merge of dm_rdata.
  hw_lane_sel #(
    .data_size(data_size)
  ) u_lane (
    .word      (dm_rdata),
    .lane      (M_ALU_result[1]),
    .new_half  (M_Rt_data[HALF_W-1:0]),
    .merged_c  (merged_c),
    .ext_half_c(ext_half_c)
  );

  assign ld_val_c = M_lh ? ext_half_c : dm_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Merge word for sh and last load result, held for the next cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      merge_q   <= '0;
      ld_hold_q <= '0;
    end else begin
      if (state_q == SH_RD) begin
        merge_q <= merged_c;
      end
      if (state_q == LD_RD) begin
        ld_hold_q <= ld_val_c;
      end
    end
  end

  // Next-state and memory/pipeline controls; stores win over loads in IDLE.
  always_comb begin
    state_d    = state_q;
    dm_wen     = 1'b0;
    dm_wdata   = '0;
    mem_stall  = 1'b0;
    M_ld_valid = 1'b0;
    M_ld_data  = ld_hold_q;

    case (state_q)
      IDLE: begin
        if (M_MemWrite) begin
          if (M_sh) begin
            mem_stall = 1'b1;
            state_d   = SH_RD;
          end else begin
            dm_wen   = 1'b1;
            dm_wdata = M_Rt_data;
          end
        end else if (M_MemtoReg) begin
          mem_stall = 1'b1;
          state_d   = LD_RD;
        end
      end
      LD_RD: begin
        M_ld_valid = 1'b1;
        M_ld_data  = ld_val_c;
        state_d    = IDLE;
      end
      SH_RD: begin
        mem_stall = 1'b1;
        state_d   = SH_WR;
      end
      SH_WR: begin
        dm_wen   = 1'b1;
        dm_wdata = merge_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset quiets the memory and pipeline controls and drops any sequence.
    if (rst) begin
      state_d    = IDLE;
      dm_wen     = 1'b0;
      dm_wdata   = '0;
      mem_stall  = 1'b0;
      M_ld_valid = 1'b0;
      M_ld_data  = '0;
    end
  end

endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Directed bench for mem_subword_ctrl with a synchronous-read memory model.
module tb_mem_subword_ctrl;

  logic        clk;
  logic        rst;
  logic        M_MemtoReg;
  logic        M_MemWrite;
  logic        M_lh;
  logic        M_sh;
  logic [31:0] M_ALU_result;
  logic [31:0] M_Rt_data;
  logic [31:0] dm_rdata;
  logic [15:0] dm_addr;
  logic        dm_wen;
  logic [31:0] dm_wdata;
  logic        mem_stall;
  logic [31:0] M_ld_data;
  logic        M_ld_valid;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;

  int n_tests;
  int n_fail;
  int stalls;

  mem_subword_ctrl #(
    .data_size(32),
    .addr_size(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .M_MemtoReg  (M_MemtoReg),
    .M_MemWrite  (M_MemWrite),
    .M_lh        (M_lh),
    .M_sh        (M_sh),
    .M_ALU_result(M_ALU_result),
    .M_Rt_data   (M_Rt_data),
    .dm_rdata    (dm_rdata),
    .dm_addr     (dm_addr),
    .dm_wen      (dm_wen),
    .dm_wdata    (dm_wdata),
    .mem_stall   (mem_stall),
    .M_ld_data   (M_ld_data),
    .M_ld_valid  (M_ld_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read word memory; bench preload port takes precedence.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (dm_wen) begin
      mem[dm_addr[5:0]] <= dm_wdata;
    end
    dm_rdata <= mem[dm_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one MEM-stage cycle of inputs on the falling edge, settle, then check.
  task automatic drive(input logic r, input logic wr, input logic sh, input logic ld,
                       input logic lh, input logic [31:0] addr, input logic [31:0] rt);
    @(negedge clk);
    rst          = r;
    M_MemWrite   = wr;
    M_sh         = sh;
    M_MemtoReg   = ld;
    M_lh         = lh;
    M_ALU_result = addr;
    M_Rt_data    = rt;
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    stalls       = 0;
    rst          = 1'b1;
    M_MemtoReg   = 1'b0;
    M_MemWrite   = 1'b0;
    M_lh         = 1'b0;
    M_sh         = 1'b0;
    M_ALU_result = 32'h0;
    M_Rt_data    = 32'h0;
    pre_we       = 1'b0;
    pre_addr     = 6'd0;
    pre_data     = 32'h0;

    // Reset overrides a presented sw and a presented load
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("rst_wen", 32'(dm_wen), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wdata", dm_wdata, 32'h0);
    chk("rst_valid", 32'(M_ld_valid), 32'd0);
    chk("rst_ld_data", M_ld_data, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("rst_ld_stall", 32'(mem_stall), 32'd0);

    // Reset in the middle of an sh: no write, back to IDLE
    preload(6'd4, 32'h1122_3344);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    chk("abort_sh_stall0", 32'(mem_stall), 32'd1);
    chk("abort_sh_wen0", 32'(dm_wen), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    chk("abort_rst_wen", 32'(dm_wen), 32'd0);
    chk("abort_rst_stall", 32'(mem_stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12, 32'h0);
    chk("abort_idle_wen", 32'(dm_wen), 32'd0);
    chk("abort_idle_stall", 32'(mem_stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12, 32'h0);
    chk("abort_no_write", mem[4], 32'h1122_3344);

    // sw: single cycle, no stall
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_addr", 32'(dm_addr), 32'd4);
    chk("sw_wen", 32'(dm_wen), 32'd1);
    chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
    chk("sw_stall", 32'(mem_stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_after_wen", 32'(dm_wen), 32'd0);

    // Store wins when store and load are both flagged
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h14, 32'h1234_5678);
    chk("prio_wen", 32'(dm_wen), 32'd1);
    chk("prio_stall", 32'(mem_stall), 32'd0);
    chk("prio_wdata", dm_wdata, 32'h1234_5678);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("prio_valid", 32'(M_ld_valid), 32'd0);

    // lh upper lane sign-extends negative, then hold, then lower lane
    preload(6'd4, 32'h8001_7FFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
    chk("lh_hi_stall", 32'(mem_stall), 32'd1);
    chk("lh_hi_valid0", 32'(M_ld_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
    chk("lh_hi_stall1", 32'(mem_stall), 32'd0);
    chk("lh_hi_valid1", 32'(M_ld_valid), 32'd1);
    chk("lh_hi_data", M_ld_data, 32'hFFFF_8001);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lh_hold_valid", 32'(M_ld_valid), 32'd0);
    chk("lh_hold_data", M_ld_data, 32'hFFFF_8001);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12, 32'h0);
    chk("lh_lo_stall", 32'(mem_stall), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12, 32'h0);
    chk("lh_lo_valid", 32'(M_ld_valid), 32'd1);
    chk("lh_lo_data", M_ld_data, 32'h0000_7FFF);

    // sh lower lane: stalls 1,1,0 then merged write
    preload(6'd4, 32'h1122_3344);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    chk("sh_lo_c0_stall", 32'(mem_stall), 32'd1);
    chk("sh_lo_c0_wen", 32'(dm_wen), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    chk("sh_lo_c1_stall", 32'(mem_stall), 32'd1);
    chk("sh_lo_c1_wen", 32'(dm_wen), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    chk("sh_lo_c2_stall", 32'(mem_stall), 32'd0);
    chk("sh_lo_c2_wen", 32'(dm_wen), 32'd1);
    chk("sh_lo_c2_addr", 32'(dm_addr), 32'd4);
    chk("sh_lo_wdata", dm_wdata, 32'h1122_BEEF);

    // sh upper lane
    preload(6'd4, 32'h1122_3344);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hAAAA_BEEF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hAAAA_BEEF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hAAAA_BEEF);
    chk("sh_hi_wen", 32'(dm_wen), 32'd1);
    chk("sh_hi_wdata", dm_wdata, 32'hBEEF_3344);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("sh_hi_mem", mem[4], 32'hBEEF_3344);

    // Back-to-back sh then lw on the same word: 5 cycles, 3 stalls
    preload(6'd4, 32'h1122_3344);
    stalls = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    stalls += int'(mem_stall);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    stalls += int'(mem_stall);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hAAAA_BEEF);
    stalls += int'(mem_stall);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    stalls += int'(mem_stall);
    chk("b2b_lw_c0_stall", 32'(mem_stall), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    stalls += int'(mem_stall);
    chk("b2b_lw_valid", 32'(M_ld_valid), 32'd1);
    chk("b2b_lw_data", M_ld_data, 32'h1122_BEEF);
    chk("b2b_stalls", 32'(stalls), 32'd3);

    // lw: full word, exactly one stall
    preload(6'd7, 32'h0BAD_F00D);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1C, 32'h0);
    chk("lw_addr", 32'(dm_addr), 32'd7);
    chk("lw_c0_stall", 32'(mem_stall), 32'd1);
    chk("lw_c0_valid", 32'(M_ld_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1C, 32'h0);
    chk("lw_c1_stall", 32'(mem_stall), 32'd0);
    chk("lw_c1_valid", 32'(M_ld_valid), 32'd1);
    chk("lw_data", M_ld_data, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_subword_ctrl.md
Name: mem_subword_ctrl

Overview:
MEM-stage sequencer between the EX/M pipeline register outputs and a synchronous-read, word-addressed data memory.
- Loads: issues a read, then returns the word or sign-extended halfword one cycle later.
- sh: performs a read-modify-write.
- Raises mem_stall so that every upstream pipeline register, including EX/M, holds while a multi-cycle access is in flight.
- Plain sw completes in one cycle with no stall.

Parameters:
- data_size, 32, data/word width in bits.
- addr_size, 16, data-memory word-address width; dm_addr = M_ALU_result[addr_size+1:2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- M_MemtoReg  in  1  instruction in MEM is a load.
- M_MemWrite  in  1  instruction in MEM is a store.
- M_lh  in  1  load is a halfword (lh); qualifies M_MemtoReg.
- M_sh  in  1  store is a halfword (sh); qualifies M_MemWrite.
- M_ALU_result  in  data_size  byte address.
- M_Rt_data  in  data_size  store data.
- dm_rdata  in  data_size  memory read data; valid the cycle after dm_addr is presented with dm_wen=0.
- dm_addr  out  addr_size  word address, combinational from M_ALU_result.
- dm_wen  out  1  memory write enable.
- dm_wdata  out  data_size  memory write data.
- mem_stall  out  1  hold IF/ID, ID/EX and EX/M registers this cycle.
- M_ld_data  out  data_size  load result.
- M_ld_valid  out  1  M_ld_data valid this cycle.

Behaviour:
- States: IDLE, LD_RD, SH_RD, SH_WR. Reset and power-up state is IDLE.
- rst=1 at a clock edge forces IDLE regardless of current state. An aborted sh performs no write.
- While rst=1: dm_wen=0, mem_stall=0, M_ld_valid=0, M_ld_data=0, dm_wdata=0.

IDLE:
- M_MemWrite & !M_sh (sw): dm_wen=1, dm_wdata=M_Rt_data, mem_stall=0. Stay in IDLE.
- M_MemWrite & M_sh: dm_wen=0, mem_stall=1, go to SH_RD.
- M_MemtoReg (lw/lh): dm_wen=0, mem_stall=1, go to LD_RD.
- None of the above: dm_wen=0, mem_stall=0.
- M_MemWrite & M_MemtoReg together is illegal. Store priority is required.

LD_RD:
- mem_stall=0, M_ld_valid=1, go to IDLE.
- M_ld_data = dm_rdata for lw. For lh, it is the selected halfword sign-extended to data_size.

SH_RD:
- mem_stall=1.
- Capture dm_rdata into the merge register, with the halfword lane replaced by M_Rt_data[15:0].
- Go to SH_WR.

SH_WR:
- dm_wen=1, dm_wdata = merge register, mem_stall=0, go to IDLE.

General rules:
- Halfword lane (big-endian): addr[1]=0 selects bits [31:16]; addr[1]=1 selects bits [15:0]. addr[0] is ignored.
- Latency: sw 1 cycle, 0 stalls. lw/lh 2 cycles, 1 stall. sh 3 cycles, 2 stalls.
- Because mem_stall=0 in the final cycle, EX/M advances exactly once per instruction, so no instruction is re-accepted. Back-to-back memory ops therefore start directly from IDLE with no bubble.
- M_ld_data holds its last value when M_ld_valid=0.
- dm_addr stays stable through a sequence because EX/M is stalled.

Decomposition:
- Shared package mem_ctrl_pkg: state encoding constants (IDLE=2'd0, LD_RD=2'd1, SH_RD=2'd2, SH_WR=2'd3) and lane-select constants.
- One sub-module, hw_lane_sel (combinational): given word, addr[1] and new halfword, returns the merged word and the sign-extended extracted halfword.

Test Plan:
- Reset mid-sh: assert rst in SH_RD -> IDLE next cycle, dm_wen never 1, mem_stall=0.
- sw: addr 0x0000_0010, Rt 0xDEADBEEF -> same cycle dm_addr=4, dm_wen=1, dm_wdata=0xDEADBEEF, mem_stall=0.
- lh sign extension: mem[4]=0x8001_7FFF, lh addr 0x10 -> 1 stall cycle, then M_ld_valid=1, M_ld_data=0xFFFF_8001. Same with addr 0x12 -> 0x0000_7FFF.
- sh merge: mem[4]=0x1122_3344, sh addr 0x12 with Rt 0xAAAA_BEEF -> mem_stall 1,1,0, then write of 0x1122_BEEF. With addr 0x10 -> 0xBEEF_3344.
- Back-to-back: sh then lw to the same word -> lw returns the merged value. Total 5 cycles, 3 stalls.
- lw: mem[7]=0x0BAD_F00D, addr 0x1C -> M_ld_data=0x0BAD_F00D in the second cycle, exactly one stall.
